// File: rtl/btn_led_pkg.sv
// Shared types and sizing helpers for the multi-channel button/LED controller.
package btn_led_pkg;

   typedef enum logic [1:0] {
      MODE_TOGGLE      = 2'b00,
      MODE_MOMENTARY   = 2'b01,
      MODE_LONG_TOGGLE = 2'b10,
      MODE_DISABLED    = 2'b11
   } mode_t;

   localparam int MAX_CH = 16;

   // Counter width able to hold the value n itself.
   function automatic int cnt_w(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: synchroniser, polarity fix, debouncer,
// press edge detector and long-press hold counter.
module btn_debounce_ch
   import btn_led_pkg::*;
#(
   parameter int DB_CYCLES    = 100_000,
   parameter int LP_CYCLES    = 10_000_000,
   parameter bit BTN_ACT_HIGH = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_raw,
   output logic db_state,
   output logic press_pulse,
   output logic long_pulse
);

   localparam int DW = cnt_w(DB_CYCLES);
   localparam int LW = cnt_w(LP_CYCLES);
   localparam logic [DW-1:0] DB_LAST = DW'(DB_CYCLES - 1);
   localparam logic [LW-1:0] LP_MAX  = LW'(LP_CYCLES);
   localparam logic [LW-1:0] LP_PRE  = LW'(LP_CYCLES - 1);
   localparam logic          REL_LVL = !BTN_ACT_HIGH;

   logic [1:0]    sync_q;
   logic          sample;
   logic          db_prev;
   logic [DW-1:0] db_cnt;
   logic [LW-1:0] hold_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= {2{REL_LVL}};
      end else begin
         sync_q <= {sync_q[0], btn_raw};
      end
   end

   assign sample = BTN_ACT_HIGH ? sync_q[1] : ~sync_q[1];

   // A level is accepted only after DB_CYCLES consecutive differing samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         db_state <= 1'b0;
         db_cnt   <= '0;
      end else if (sample == db_state) begin
         db_cnt   <= '0;
      end else if (db_cnt == DB_LAST) begin
         db_state <= sample;
         db_cnt   <= '0;
      end else begin
         db_cnt   <= db_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         db_prev     <= 1'b0;
         press_pulse <= 1'b0;
      end else begin
         db_prev     <= db_state;
         press_pulse <= db_state & ~db_prev;
      end
   end

   // Saturating hold counter: one long pulse per hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt   <= '0;
         long_pulse <= 1'b0;
      end else begin
         long_pulse <= db_state && (hold_cnt == LP_PRE);
         if (!db_state) begin
            hold_cnt <= '0;
         end else if (hold_cnt != LP_MAX) begin
            hold_cnt <= hold_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/button_led_ctrl_multi.sv
// Multi-channel button-to-LED controller with per-channel
// run-time mode selection (toggle, momentary, long-toggle, disabled).
module button_led_ctrl_multi
   import btn_led_pkg::*;
#(
   parameter int NUM_CH       = 4,
   parameter int DB_CYCLES    = 100_000,
   parameter int LP_CYCLES    = 10_000_000,
   parameter bit BTN_ACT_HIGH = 1'b1,
   parameter bit LED_ACT_LOW  = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_CH-1:0]     btn_raw,
   input  logic [2*NUM_CH-1:0]   mode,
   output logic [NUM_CH-1:0]     led_out,
   output logic [NUM_CH-1:0]     led_state,
   output logic [NUM_CH-1:0]     press_pulse,
   output logic [NUM_CH-1:0]     long_pulse
);

   logic [NUM_CH-1:0] db_state;
   logic [NUM_CH-1:0] led_nxt;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      mode_t mode_i;
      mode_t mode_q;
      logic  led_n;

      btn_debounce_ch #(
         .DB_CYCLES    (DB_CYCLES),
         .LP_CYCLES    (LP_CYCLES),
         .BTN_ACT_HIGH (BTN_ACT_HIGH)
      ) u_ch (
         .clk         (clk),
         .rst_n       (rst_n),
         .btn_raw     (btn_raw[i]),
         .db_state    (db_state[i]),
         .press_pulse (press_pulse[i]),
         .long_pulse  (long_pulse[i])
      );

      assign mode_i = mode_t'(mode[2*i +: 2]);

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            mode_q <= MODE_TOGGLE;
         end else begin
            mode_q <= mode_i;
         end
      end

      // A mode switch blanks the LED and swallows any coincident toggle.
      always_comb begin
         led_n = led_state[i];
         if (mode_i != mode_q) begin
            led_n = 1'b0;
         end else begin
            unique case (mode_i)
               MODE_TOGGLE:      led_n = led_state[i] ^ press_pulse[i];
               MODE_MOMENTARY:   led_n = db_state[i];
               MODE_LONG_TOGGLE: led_n = led_state[i] ^ long_pulse[i];
               MODE_DISABLED:    led_n = 1'b0;
               default:          led_n = 1'b0;
            endcase
         end
      end

      assign led_nxt[i] = led_n;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led_state <= '0;
         led_out   <= {NUM_CH{LED_ACT_LOW}};
      end else begin
         led_state <= led_nxt;
         led_out   <= led_nxt ^ {NUM_CH{LED_ACT_LOW}};
      end
   end

endmodule
